// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared state encoding, defaults and helpers for uart_tx_arb.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t c_st_idle = 2'd0;
  localparam arb_state_t c_st_wait = 2'd1;
  localparam arb_state_t c_st_hold = 2'd2;

  localparam int c_tx_tmo_def  = 512;
  localparam int c_gap_max_def = 64;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker, searches upward from ptr_i.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from farthest to nearest so the requester closest to ptr_i wins.
  always_comb begin : p_pick
    int            j;
    logic [IW-1:0] jj;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    j        = 0;
    jj       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j  = (int'(ptr_i) + k) % N;
      jj = IW'(j);
      if (req_i[jj]) begin
        onehot_o     = '0;
        onehot_o[jj] = 1'b1;
        idx_o        = jj;
        any_o        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Frame-granular round-robin arbiter feeding one UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TX_TMO  = c_tx_tmo_def,
  parameter int GAP_MAX = c_gap_max_def
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_vld,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 err_tmo,
  output logic                 err_gap
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TX_TMO + 1);
  localparam int GW = $clog2(GAP_MAX + 1);
  localparam logic [TW-1:0] c_tmo_last = TW'(TX_TMO - 1);
  localparam logic [GW-1:0] c_gap_last = GW'(GAP_MAX - 1);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               last_q, last_d;
  logic               trmt_q, trmt_d;
  logic [7:0]         data_q, data_d;
  logic               etmo_q, etmo_d;
  logic               egap_q, egap_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;
  logic               w_send;
  logic               w_end;
  logic [IW-1:0]      w_send_idx;
  logic [NUM_REQ-1:0] w_send_oh;
  logic [7:0]         w_byte;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i    (req_vld),
    .ptr_i    (rr_q),
    .onehot_o (w_pick_oh),
    .idx_o    (w_pick_idx),
    .any_o    (w_pick_any)
  );

  // Once a frame owns the transmitter only the owner's lane is considered.
  assign w_send     = ((state_q == c_st_idle) && w_pick_any) ||
                      ((state_q == c_st_hold) && req_vld[idx_q]);
  assign w_send_idx = (state_q == c_st_idle) ? w_pick_idx : idx_q;
  assign w_send_oh  = (state_q == c_st_idle) ? w_pick_oh  : grant_q;

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == w_send_idx) w_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    last_d  = last_q;
    trmt_d  = 1'b0;
    data_d  = data_q;
    ack_d   = '0;
    etmo_d  = 1'b0;
    egap_d  = 1'b0;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    w_end   = 1'b0;

    case (state_q)
      c_st_idle: ;
      // tmo_q == 0 marks the trmt cycle, where tx_done may still be stale.
      c_st_wait: begin
        if ((tmo_q != '0) && tx_done) begin
          if (last_q) begin
            w_end = 1'b1;
          end else begin
            state_d = c_st_hold;
            gap_d   = '0;
            tmo_d   = '0;
          end
        end else if (tmo_q == c_tmo_last) begin
          etmo_d = 1'b1;
          w_end  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      c_st_hold: begin
        if (!req_vld[idx_q]) begin
          if (gap_q == c_gap_last) begin
            egap_d = 1'b1;
            w_end  = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = c_st_idle;
    endcase

    if (w_send) begin
      state_d = c_st_wait;
      idx_d   = w_send_idx;
      grant_d = w_send_oh;
      ack_d   = w_send_oh;
      trmt_d  = 1'b1;
      data_d  = w_byte;
      last_d  = req_last[w_send_idx];
      tmo_d   = '0;
      gap_d   = '0;
    end

    if (w_end) begin
      state_d = c_st_idle;
      grant_d = '0;
      rr_d    = IW'(rr_next(int'(idx_q), NUM_REQ));
      tmo_d   = '0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_st_idle;
      rr_q    <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      last_q  <= 1'b0;
      trmt_q  <= 1'b0;
      data_q  <= '0;
      etmo_q  <= 1'b0;
      egap_q  <= 1'b0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      trmt_q  <= trmt_d;
      data_q  <= data_d;
      etmo_q  <= etmo_d;
      egap_q  <= egap_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  assign req_ack = ack_q;
  assign trmt    = trmt_q;
  assign tx_data = data_q;
  assign grant   = grant_q;
  assign busy    = (state_q != c_st_idle);
  assign err_tmo = etmo_q;
  assign err_gap = egap_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arb
// Brief    : Directed and randomized self-checking bench for uart_tx_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

  localparam int N   = 3;
  localparam int TMO = 20;
  localparam int GAP = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic           trmt;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic [N-1:0]   grant;
  logic           busy;
  logic           err_tmo;
  logic           err_gap;

  uart_tx_arb #(
    .NUM_REQ (N),
    .TX_TMO  (TMO),
    .GAP_MAX (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .grant    (grant),
    .busy     (busy),
    .err_tmo  (err_tmo),
    .err_gap  (err_gap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_at = -1;
  int done_at = -1;
  int done_cyc = -1;
  int uart_lat = 3;
  bit rand_lat = 1'b0;
  bit sb_en = 1'b0;
  bit auto_src = 1'b0;
  bit err_seen = 1'b0;
  int w, n, nf, len;
  logic [N-1:0] oh_k;

  logic [8:0] src_mem [N][16];
  int         src_n   [N];
  int         src_pos [N];
  int         exp_q   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic t, input logic [7:0] d, input logic [N-1:0] a,
                                     input logic [N-1:0] g, input logic b, input logic et,
                                     input logic eg);
    return 32'({t, d, a, g, b, et, eg});
  endfunction

  function automatic logic [31:0] outs();
    return mk(trmt, tx_data, req_ack, grant, busy, err_tmo, err_gap);
  endfunction

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_n[i]) begin
        req_vld[i]          = 1'b1;
        req_data[8*i +: 8]  = src_mem[i][src_pos[i]][7:0];
        req_last[i]         = src_mem[i][src_pos[i]][8];
      end else begin
        req_vld[i]  = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  // One clock: UART model (drops tx_done the cycle after trmt, raises it
  // uart_lat cycles later), scoreboard, and auto-advancing requesters.
  task automatic tick();
    int           id;
    logic [N-1:0] oh;
    logic [7:0]   b;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == drop_at) tx_done = 1'b0;
    if (cyc == done_at) begin
      tx_done  = 1'b1;
      done_cyc = cyc;
    end
    if (trmt) begin
      if (rand_lat) uart_lat = int'($urandom_range(6, 1));
      drop_at = cyc + 1;
      done_at = (uart_lat > 0) ? cyc + 1 + uart_lat : -1;
    end
    if (sb_en) begin
      if (err_tmo || err_gap) err_seen = 1'b1;
      if (trmt) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_trmt", 32'(trmt), 32'd0);
        end else begin
          id = exp_q.pop_front();
          oh = N'(1) << (id >> 8);
          b  = 8'(id & 255);
          chk("sb_byte", 32'({req_ack, grant, tx_data}), 32'({oh, oh, b}));
        end
      end
    end
    if (auto_src) begin
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) src_pos[i]++;
      end
      drive_src();
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    tx_done  = 1'b1;
    auto_src = 1'b0;
    sb_en    = 1'b0;
    tick();
    tick();
    rst     = 1'b0;
    drop_at = -1;
    done_at = -1;
  endtask

  // Expected stream: whole frames, round-robin over requesters that still
  // have frames, starting at requester 0 and moving past each served one.
  task automatic run_frames();
    int         ptr;
    int         found;
    int         idx;
    int         fpos [N];
    bit         more;
    logic [8:0] e;
    exp_q.delete();
    ptr = 0;
    for (int i = 0; i < N; i++) begin
      fpos[i]    = 0;
      src_pos[i] = 0;
    end
    more = 1'b1;
    while (more) begin
      found = -1;
      for (int k = N - 1; k >= 0; k--) begin
        idx = (ptr + k) % N;
        if (fpos[idx] < src_n[idx]) found = idx;
      end
      if (found < 0) begin
        more = 1'b0;
      end else begin
        do begin
          e = src_mem[found][fpos[found]];
          exp_q.push_back(found * 256 + int'(e[7:0]));
          fpos[found]++;
        end while (!e[8] && (fpos[found] < src_n[found]));
        ptr = (found + 1) % N;
      end
    end
    err_seen = 1'b0;
    sb_en    = 1'b1;
    auto_src = 1'b1;
    drive_src();
    n = 0;
    while (((exp_q.size() != 0) || busy) && (n < 2000)) begin
      tick();
      n++;
    end
    chk("run_drained", 32'(exp_q.size()), 32'd0);
    chk("run_idle", 32'(busy), 32'd0);
    chk("run_no_err", 32'(err_seen), 32'd0);
    sb_en    = 1'b0;
    auto_src = 1'b0;
    req_vld  = '0;
  endtask

  initial begin
    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    tx_done  = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_n[i]   = 0;
      src_pos[i] = 0;
    end

    // Reset state
    do_reset();
    chk("reset_outs", outs(), 32'd0);

    // Single byte from requester 1, with tx_done stale-high on the trmt cycle
    req_vld  = 3'b010;
    req_data = 24'h005A00;
    req_last = 3'b010;
    tick();
    w = cyc;
    req_vld = '0;
    chk("single_send", outs(), mk(1'b1, 8'h5A, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0));
    tick();
    chk("stale_done_hold", 32'({grant, busy}), 32'({3'b010, 1'b1}));
    while (cyc < w + 4) tick();
    chk("single_wait", 32'({grant, busy}), 32'({3'b010, 1'b1}));
    tick();
    chk("single_end", 32'({grant, busy, trmt, req_ack}), 32'd0);
    req_vld  = 3'b111;
    req_data = 24'h332211;
    req_last = 3'b111;
    tick();
    chk("rr_ptr_after_single", 32'({trmt, grant, tx_data}), 32'({1'b1, 3'b100, 8'h33}));

    // Contention: all three valid, one-byte frames
    do_reset();
    req_vld  = 3'b111;
    req_data = 24'h332211;
    req_last = 3'b111;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!trmt && (n < 40));
      oh_k = N'(1) << (k % 3);
      chk("cont_grant", 32'({trmt, grant}), 32'({1'b1, oh_k}));
      if (k > 0) chk("cont_done_to_trmt", 32'(cyc - done_cyc), 32'd2);
    end

    // Frame lock: requester 0 sends 3 bytes while requester 2 waits
    do_reset();
    for (int i = 0; i < N; i++) src_n[i] = 0;
    src_mem[0][0] = {1'b0, 8'hA1};
    src_mem[0][1] = {1'b0, 8'hA2};
    src_mem[0][2] = {1'b1, 8'hA3};
    src_n[0]      = 3;
    src_mem[2][0] = {1'b1, 8'hC1};
    src_n[2]      = 1;
    uart_lat      = 3;
    run_frames();

    // Randomized frames and UART latencies
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        src_n[i] = 0;
        nf = int'($urandom_range(3, 0));
        for (int f = 0; f < nf; f++) begin
          len = int'($urandom_range(4, 1));
          for (int b = 0; b < len; b++) begin
            src_mem[i][src_n[i]] = {(b == len - 1), 8'($urandom)};
            src_n[i]++;
          end
        end
      end
      rand_lat = 1'b1;
      run_frames();
      rand_lat = 1'b0;
      uart_lat = 3;
    end

    // Timeout: tx_done never returns
    do_reset();
    uart_lat = 0;
    req_vld  = 3'b010;
    req_data = 24'h007700;
    req_last = 3'b010;
    tick();
    w = cyc;
    req_vld = '0;
    chk("tmo_send", 32'({trmt, grant}), 32'({1'b1, 3'b010}));
    while (cyc < w + TMO - 1) tick();
    chk("tmo_before", 32'({err_tmo, grant, busy}), 32'({1'b0, 3'b010, 1'b1}));
    tick();
    chk("tmo_pulse", 32'({err_tmo, grant, busy}), 32'({1'b1, 3'b000, 1'b0}));
    tick();
    chk("tmo_one_cycle", 32'(err_tmo), 32'd0);

    // Timeout tie: tx_done arrives on the last allowed cycle
    do_reset();
    uart_lat = 0;
    req_vld  = 3'b010;
    req_data = 24'h007700;
    req_last = 3'b010;
    tick();
    w       = cyc;
    done_at = w + TMO - 1;
    req_vld = '0;
    while (cyc < w + TMO) tick();
    chk("tmo_tie", 32'({err_tmo, grant, busy}), 32'd0);
    uart_lat = 3;

    // Gap abort after a non-last byte
    do_reset();
    req_vld  = 3'b001;
    req_data = 24'h000010;
    req_last = 3'b000;
    tick();
    w = cyc;
    req_vld = '0;
    chk("gap_send", 32'({trmt, grant, tx_data}), 32'({1'b1, 3'b001, 8'h10}));
    while (cyc < w + 4 + GAP) tick();
    chk("gap_before", 32'({err_gap, grant, busy}), 32'({1'b0, 3'b001, 1'b1}));
    tick();
    chk("gap_pulse", 32'({err_gap, grant, busy}), 32'({1'b1, 3'b000, 1'b0}));
    tick();
    chk("gap_one_cycle", 32'(err_gap), 32'd0);

    // Next byte arrives on the last allowed idle cycle
    do_reset();
    req_vld  = 3'b001;
    req_data = 24'h000010;
    req_last = 3'b000;
    tick();
    w = cyc;
    req_vld = '0;
    while (cyc < w + 4 + GAP) tick();
    req_vld  = 3'b001;
    req_data = 24'h000020;
    req_last = 3'b001;
    tick();
    req_vld = '0;
    chk("gap_edge_send", 32'({trmt, err_gap, grant, tx_data}), 32'({1'b1, 1'b0, 3'b001, 8'h20}));

    // Reset in the middle of WAIT
    do_reset();
    req_vld  = 3'b100;
    req_data = 24'h990000;
    req_last = 3'b100;
    tick();
    req_vld = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_midframe", outs(), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_after", 32'({err_tmo, err_gap, busy, trmt}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
